alu_pipe: RTL and testbench

Parametrised, streaming successor to the integer ALU, sitting between the control unit and the register-file write-back path. Operands and operation travel together under a valid/ready handshake through a configurable-depth result pipeline with backpressure. It executes RV32I-style I/R ops and branch comparisons, and flags each result individually. A sticky error flag is exposed for the control unit's halt logic.

---
 rtl/alu_pipe_if.sv | 35 +++
 rtl/alu_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_pipe.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/operation request side and result side of the
// streaming ALU, bundled so producer and consumer hook up with one port.
interface alu_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_dat1;
   logic [XLEN-1:0] in_dat2;
   logic [2:0]      in_funct3;
   logic            in_alt;
   logic            in_branch;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_overflow;
   logic            out_con_met;
   logic            out_zero;
   logic            out_err;
   logic            err_sticky;

   // Control unit side: presents operations and consumes results
   modport master (
      output in_valid, in_dat1, in_dat2, in_funct3, in_alt, in_branch, out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_con_met,
             out_zero, out_err, err_sticky
   );

   // ALU side: accepts operations and produces results
   modport slave (
      input  in_valid, in_dat1, in_dat2, in_funct3, in_alt, in_branch, out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_con_met,
             out_zero, out_err, err_sticky
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: RV32I-style ALU and branch comparator. The result and its flags
// are computed when an operation is accepted and then ride through LATENCY
// stages that all advance together whenever the output is free.
module alu_pipe #(
   parameter int XLEN    = 32,
   parameter int LATENCY = 2
) (
   input  logic         soc_clk,
   input  logic         reset,
   alu_pipe_if.slave    bus
);
   localparam int SHW = $clog2(XLEN);
   localparam int MSB = XLEN - 1;

   generate
      if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0 || LATENCY < 1 || LATENCY > 4) begin : g_badParam
         $error("alu_pipe: XLEN must be a power of 2 >= 8 and LATENCY in 1..4");
      end
   endgenerate

   logic            w_adv;
   logic [XLEN-1:0] w_sum;
   logic [XLEN-1:0] w_diff;
   logic [SHW-1:0]  w_shamt;
   logic            w_lts;
   logic            w_ltu;
   logic [XLEN-1:0] w_result;
   logic            w_ovf;
   logic            w_con;
   logic            w_zero;
   logic            w_err;

   logic            r_valid  [LATENCY];
   logic [XLEN-1:0] r_result [LATENCY];
   logic            r_ovf    [LATENCY];
   logic            r_con    [LATENCY];
   logic            r_zero   [LATENCY];
   logic            r_err    [LATENCY];
   logic            r_sticky;

   // The whole pipe moves only when the last stage is empty or being taken
   assign w_adv = !r_valid[LATENCY-1] || bus.out_ready;

   // Decode and execute the presented operation; a bubble yields all zeros
   always_comb begin
      w_result = '0;
      w_ovf    = 1'b0;
      w_con    = 1'b0;
      w_err    = 1'b0;
      w_sum    = bus.in_dat1 + bus.in_dat2;
      w_diff   = bus.in_dat1 - bus.in_dat2;
      w_shamt  = bus.in_dat2[SHW-1:0];
      w_lts    = $signed(bus.in_dat1) < $signed(bus.in_dat2);
      w_ltu    = bus.in_dat1 < bus.in_dat2;
      if (bus.in_valid) begin
         if (bus.in_branch) begin
            if (bus.in_alt) begin
               w_err = 1'b1;
            end else begin
               case (bus.in_funct3)
                  3'b000:  w_con = (bus.in_dat1 == bus.in_dat2);
                  3'b001:  w_con = (bus.in_dat1 != bus.in_dat2);
                  3'b100:  w_con = w_lts;
                  3'b101:  w_con = !w_lts;
                  3'b110:  w_con = w_ltu;
                  3'b111:  w_con = !w_ltu;
                  default: w_err = 1'b1;
               endcase
            end
         end else if (bus.in_alt) begin
            case (bus.in_funct3)
               3'b000: begin
                  w_result = w_diff;
                  w_ovf    = (bus.in_dat1[MSB] != bus.in_dat2[MSB]) && (w_diff[MSB] != bus.in_dat1[MSB]);
               end
               3'b101:  w_result = XLEN'($signed(bus.in_dat1) >>> w_shamt);
               default: w_err = 1'b1;
            endcase
         end else begin
            case (bus.in_funct3)
               3'b000: begin
                  w_result = w_sum;
                  w_ovf    = (bus.in_dat1[MSB] == bus.in_dat2[MSB]) && (w_sum[MSB] != bus.in_dat1[MSB]);
               end
               3'b001: w_result = bus.in_dat1 << w_shamt;
               3'b010: begin
                  w_result = {{(XLEN-1){1'b0}}, w_lts};
                  w_con    = w_lts;
               end
               3'b011: begin
                  w_result = {{(XLEN-1){1'b0}}, w_ltu};
                  w_con    = w_ltu;
               end
               3'b100: w_result = bus.in_dat1 ^ bus.in_dat2;
               3'b101: w_result = bus.in_dat1 >> w_shamt;
               3'b110: w_result = bus.in_dat1 | bus.in_dat2;
               default: w_result = bus.in_dat1 & bus.in_dat2;
            endcase
         end
      end
      w_zero = bus.in_valid && !bus.in_branch && !w_err && (w_result == '0);
   end

   // Result pipeline: capture at stage 0, shift every stage together, freeze on stall
   always_ff @(posedge soc_clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < LATENCY; k++) begin
            r_valid[k]  <= 1'b0;
            r_result[k] <= '0;
            r_ovf[k]    <= 1'b0;
            r_con[k]    <= 1'b0;
            r_zero[k]   <= 1'b0;
            r_err[k]    <= 1'b0;
         end
      end else if (w_adv) begin
         r_valid[0]  <= bus.in_valid;
         r_result[0] <= w_result;
         r_ovf[0]    <= w_ovf;
         r_con[0]    <= w_con;
         r_zero[0]   <= w_zero;
         r_err[0]    <= w_err;
         for (int k = 1; k < LATENCY; k++) begin
            r_valid[k]  <= r_valid[k-1];
            r_result[k] <= r_result[k-1];
            r_ovf[k]    <= r_ovf[k-1];
            r_con[k]    <= r_con[k-1];
            r_zero[k]   <= r_zero[k-1];
            r_err[k]    <= r_err[k-1];
         end
      end
   end

   // Remember that an illegal op was handed to the consumer until the next reset
   always_ff @(posedge soc_clk or posedge reset) begin
      if (reset) begin
         r_sticky <= 1'b0;
      end else if (r_valid[LATENCY-1] && bus.out_ready && r_err[LATENCY-1]) begin
         r_sticky <= 1'b1;
      end
   end

   assign bus.in_ready     = w_adv;
   assign bus.out_valid    = r_valid[LATENCY-1];
   assign bus.out_result   = r_result[LATENCY-1];
   assign bus.out_overflow = r_ovf[LATENCY-1];
   assign bus.out_con_met  = r_con[LATENCY-1];
   assign bus.out_zero     = r_zero[LATENCY-1];
   assign bus.out_err      = r_err[LATENCY-1];
   assign bus.err_sticky   = r_sticky;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: drives three alu_pipe instances (32/2, 32/4, 64/1). The 32/2
// instance is scoreboarded every cycle against a behavioural model; the other
// two cover latency, wide operands and reset with ops in flight.
module tb_alu_pipe;
   typedef struct {
      logic [63:0] res;
      logic        ovf;
      logic        con;
      logic        zero;
      logic        err;
   } expT;

   logic soc_clk;
   logic reset;
   int   nChecks = 0;
   int   nFail   = 0;
   int   nPops   = 0;
   logic expSticky = 1'b0;
   expT  q[$];

   alu_pipe_if #(.XLEN(32)) busA();
   alu_pipe_if #(.XLEN(32)) busB();
   alu_pipe_if #(.XLEN(64)) busC();

   alu_pipe #(.XLEN(32), .LATENCY(2)) dutA (.soc_clk(soc_clk), .reset(reset), .bus(busA));
   alu_pipe #(.XLEN(32), .LATENCY(4)) dutB (.soc_clk(soc_clk), .reset(reset), .bus(busB));
   alu_pipe #(.XLEN(64), .LATENCY(1)) dutC (.soc_clk(soc_clk), .reset(reset), .bus(busC));

   // Free-running clock, 10 time units per cycle
   initial soc_clk = 1'b0;
   always #5 soc_clk = ~soc_clk;

   // What the ALU must produce for one operation, worked out arithmetically
   function automatic expT refOp(input int xlen, input logic [63:0] a0, input logic [63:0] b0,
                                 input logic br, input logic alt, input logic [2:0] f3);
      expT         e;
      logic [63:0] mask;
      logic [63:0] a;
      logic [63:0] b;
      longint      sa;
      longint      sb;
      int          sh;
      mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xlen) - 64'd1);
      a    = a0 & mask;
      b    = b0 & mask;
      sa   = a[xlen-1] ? longint'(a | ~mask) : longint'(a);
      sb   = b[xlen-1] ? longint'(b | ~mask) : longint'(b);
      sh   = int'(b % 64'(xlen));
      e.res = '0; e.ovf = 1'b0; e.con = 1'b0; e.zero = 1'b0; e.err = 1'b0;
      if (br) begin
         if (alt) e.err = 1'b1;
         else case (f3)
            3'b000:  e.con = (a == b);
            3'b001:  e.con = (a != b);
            3'b100:  e.con = (sa < sb);
            3'b101:  e.con = (sa >= sb);
            3'b110:  e.con = (a < b);
            3'b111:  e.con = (a >= b);
            default: e.err = 1'b1;
         endcase
      end else begin
         case ({alt, f3})
            4'b0000: begin
               e.res = (a + b) & mask;
               e.ovf = ((sa < 0) == (sb < 0)) && (e.res[xlen-1] != (sa < 0));
            end
            4'b1000: begin
               e.res = (a - b) & mask;
               e.ovf = ((sa < 0) != (sb < 0)) && (e.res[xlen-1] != (sa < 0));
            end
            4'b0001: e.res = (a << sh) & mask;
            4'b0010: begin e.con = (sa < sb); e.res = 64'(e.con); end
            4'b0011: begin e.con = (a < b);   e.res = 64'(e.con); end
            4'b0100: e.res = a ^ b;
            4'b0101: e.res = a >> sh;
            4'b1101: e.res = 64'(sa >>> sh) & mask;
            4'b0110: e.res = a | b;
            4'b0111: e.res = a & b;
            default: e.err = 1'b1;
         endcase
         e.zero = !e.err && (e.res == 64'd0);
      end
      return e;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge soc_clk);
      #2;
   endtask

   task automatic applyStimulus(input logic br, input logic alt, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b);
      busA.in_valid  = 1'b1;
      busA.in_branch = br;
      busA.in_alt    = alt;
      busA.in_funct3 = f3;
      busA.in_dat1   = a;
      busA.in_dat2   = b;
   endtask

   // One op through the 32/2 instance with no stall; afterwards its result is visible
   task automatic runOneA(input logic br, input logic alt, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
      applyStimulus(br, alt, f3, a, b);
      busA.out_ready = 1'b1;
      tick();
      busA.in_valid = 1'b0;
      checkOutput("A_not_yet_valid", 64'(busA.out_valid), 64'd0);
      tick();
      checkOutput("A_valid_after_latency", 64'(busA.out_valid), 64'd1);
   endtask

   // Record each accepted op in the model queue and retire each handed-out result
   always @(posedge soc_clk or posedge reset) begin
      if (reset) begin
         q.delete();
         expSticky = 1'b0;
      end else begin
         if (busA.out_valid && busA.out_ready && q.size() > 0) begin
            if (q[0].err) expSticky = 1'b1;
            void'(q.pop_front());
            nPops++;
         end
         if (busA.in_valid && busA.in_ready)
            q.push_back(refOp(32, 64'(busA.in_dat1), 64'(busA.in_dat2),
                              busA.in_branch, busA.in_alt, busA.in_funct3));
      end
   end

   // Every cycle the 32/2 outputs must match the oldest outstanding model result
   always @(negedge soc_clk) begin
      if (!reset) begin
         checkOutput("A_in_ready", 64'(busA.in_ready), 64'(!busA.out_valid || busA.out_ready));
         checkOutput("A_err_sticky", 64'(busA.err_sticky), 64'(expSticky));
         if (busA.out_valid) begin
            if (q.size() == 0) begin
               checkOutput("A_unexpected_output", 64'(busA.out_valid), 64'd0);
            end else begin
               checkOutput("A_result",   64'(busA.out_result),   q[0].res);
               checkOutput("A_overflow", 64'(busA.out_overflow), 64'(q[0].ovf));
               checkOutput("A_con_met",  64'(busA.out_con_met),  64'(q[0].con));
               checkOutput("A_zero",     64'(busA.out_zero),     64'(q[0].zero));
               checkOutput("A_err",      64'(busA.out_err),      64'(q[0].err));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pat[4] = '{1, 0, 0, 1};
      int sent;
      int cyc;
      int cnt;
      int popsBefore;
      logic willAccept;

      reset = 1'b1;
      busA.in_valid = 1'b0; busA.in_branch = 1'b0; busA.in_alt = 1'b0; busA.in_funct3 = '0;
      busA.in_dat1 = '0; busA.in_dat2 = '0; busA.out_ready = 1'b1;
      busB.in_valid = 1'b0; busB.in_branch = 1'b0; busB.in_alt = 1'b0; busB.in_funct3 = '0;
      busB.in_dat1 = '0; busB.in_dat2 = '0; busB.out_ready = 1'b1;
      busC.in_valid = 1'b0; busC.in_branch = 1'b0; busC.in_alt = 1'b0; busC.in_funct3 = '0;
      busC.in_dat1 = '0; busC.in_dat2 = '0; busC.out_ready = 1'b1;
      tick(); tick(); tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_in_ready",   64'(busA.in_ready),   64'd1);
      checkOutput("rst_out_valid",  64'(busA.out_valid),  64'd0);
      checkOutput("rst_result",     64'(busA.out_result), 64'd0);
      checkOutput("rst_sticky",     64'(busA.err_sticky), 64'd0);
      checkOutput("rst_B_valid",    64'(busB.out_valid),  64'd0);
      checkOutput("rst_C_valid",    64'(busC.out_valid),  64'd0);

      // Hand-computed results
      runOneA(1'b0, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
      checkOutput("add_ovf_result", 64'(busA.out_result),   64'h8000_0000);
      checkOutput("add_ovf_flag",   64'(busA.out_overflow), 64'd1);
      checkOutput("add_ovf_zero",   64'(busA.out_zero),     64'd0);
      runOneA(1'b0, 1'b1, 3'b000, 32'd5, 32'd5);
      checkOutput("sub_zero_result", 64'(busA.out_result),   64'd0);
      checkOutput("sub_zero_flag",   64'(busA.out_zero),     64'd1);
      checkOutput("sub_zero_ovf",    64'(busA.out_overflow), 64'd0);
      runOneA(1'b0, 1'b1, 3'b101, 32'h8000_0000, 32'h0000_0024);
      checkOutput("sra_result", 64'(busA.out_result), 64'hF800_0000);
      runOneA(1'b1, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1);
      checkOutput("bltu_con",    64'(busA.out_con_met), 64'd0);
      checkOutput("bltu_result", 64'(busA.out_result),  64'd0);
      runOneA(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1);
      checkOutput("blt_con", 64'(busA.out_con_met), 64'd1);

      // Illegal branch encoding and the sticky flag
      runOneA(1'b1, 1'b0, 3'b010, 32'h1234, 32'h5678);
      checkOutput("illegal_err",      64'(busA.out_err),    64'd1);
      checkOutput("illegal_result",   64'(busA.out_result), 64'd0);
      checkOutput("sticky_before_hs", 64'(busA.err_sticky), 64'd0);
      tick();
      checkOutput("sticky_after_hs",  64'(busA.err_sticky), 64'd1);
      runOneA(1'b0, 1'b0, 3'b110, 32'hF0, 32'h0F);
      checkOutput("sticky_holds",     64'(busA.err_sticky), 64'd1);
      tick();

      // Eight back-to-back ops under a 1,0,0,1 out_ready pattern
      popsBefore = nPops;
      sent = 0;
      cyc  = 0;
      while (sent < 8 && cyc < 200) begin
         applyStimulus(1'b0, (sent == 5), 3'(sent), 32'(sent * 32'h1111_1111), 32'(sent + 1));
         busA.out_ready = pat[cyc % 4][0];
         #1;
         willAccept = busA.in_ready;
         tick();
         if (willAccept) sent++;
         cyc++;
      end
      checkOutput("stream_all_sent", 64'(sent), 64'd8);
      busA.in_valid  = 1'b0;
      busA.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checkOutput("stream_emitted", 64'(nPops - popsBefore), 64'd8);

      // Randomized operations with random backpressure
      for (int c = 0; c < 400; c++) begin
         busA.in_valid  = ($urandom_range(0, 9) < 8);
         busA.in_branch = ($urandom_range(0, 2) == 0);
         busA.in_alt    = ($urandom_range(0, 3) == 0);
         busA.in_funct3 = 3'($urandom);
         busA.in_dat1   = pickOperand();
         busA.in_dat2   = pickOperand();
         busA.out_ready = ($urandom_range(0, 9) < 7);
         tick();
      end
      busA.in_valid  = 1'b0;
      busA.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checkOutput("random_drained", 64'(q.size()), 64'd0);

      // Latency of the 32/4 instance
      busB.in_valid = 1'b1; busB.in_funct3 = 3'b000; busB.in_dat1 = 32'd3; busB.in_dat2 = 32'd4;
      tick();
      busB.in_valid = 1'b0;
      cnt = 0;
      while (!busB.out_valid && cnt < 10) begin tick(); cnt++; end
      checkOutput("B_latency", 64'(cnt), 64'd3);
      checkOutput("B_result",  64'(busB.out_result), 64'd7);

      // Latency and wide operands on the 64/1 instance
      busC.in_valid = 1'b1; busC.in_funct3 = 3'b000;
      busC.in_dat1 = 64'h7FFF_FFFF_FFFF_FFFF; busC.in_dat2 = 64'd1;
      tick();
      busC.in_valid = 1'b0;
      cnt = 0;
      while (!busC.out_valid && cnt < 10) begin tick(); cnt++; end
      checkOutput("C_latency",  64'(cnt), 64'd0);
      checkOutput("C_result",   busC.out_result, 64'h8000_0000_0000_0000);
      checkOutput("C_overflow", 64'(busC.out_overflow), 64'd1);
      busC.in_valid = 1'b1; busC.in_alt = 1'b1; busC.in_funct3 = 3'b101;
      busC.in_dat1 = 64'h8000_0000_0000_0000; busC.in_dat2 = 64'h44;
      tick();
      busC.in_valid = 1'b0; busC.in_alt = 1'b0;
      checkOutput("C_sra", busC.out_result, 64'hF800_0000_0000_0000);
      tick();

      // Reset with two ops in flight in the 32/4 instance
      busB.in_valid = 1'b1; busB.in_dat1 = 32'd1; busB.in_dat2 = 32'd2;
      tick();
      tick();
      busB.in_valid = 1'b0;
      checkOutput("B_inflight_not_out", 64'(busB.out_valid), 64'd0);
      #1 reset = 1'b1;
      #1;
      checkOutput("B_valid_in_reset",  64'(busB.out_valid),  64'd0);
      checkOutput("A_sticky_cleared",  64'(busA.err_sticky), 64'd0);
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutput("B_nothing_after_reset", 64'(busB.out_valid), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
